// File: rtl/jellyvl_graycode_pkg.sv
// Shared gray-code helpers and the synchroniser FSM state type.
// The conversion functions work on a fixed maximum width; callers
// zero-extend their operands and truncate the result, which is exact
// because leading zero bits do not alter either conversion.
package jellyvl_graycode_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/jellyvl_graycode_step_check.sv
// Sticky detector for lossy gray transitions: flags a sample pair that
// differs in more than one bit. Only compiled when the optional checker
// is enabled with JELLYVL_CDC_GRAY_STEP_CHECK_EN.
`ifdef JELLYVL_CDC_GRAY_STEP_CHECK_EN
module jellyvl_graycode_step_check #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic             check_en,
  input  logic             clear,
  output logic             err
);

  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  // More than one set bit in the difference: x & (x-1) is nonzero.
  always_comb begin
    diff      = prev ^ cur;
    multi_bit = (diff & (diff - WIDTH'(1))) != '0;
  end

  // Sticky error; a new error takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (check_en && multi_bit) begin
      err <= 1'b1;
    end else if (clear) begin
      err <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/jellyvl_cdc_gray_multi_sync.sv
// Destination-side synchroniser for NUM_CH independent gray-coded counters.
// Each channel passes through a SYNC_FF-deep flop chain, is decoded to
// binary and reports its value, the modular increment and a change pulse.
// Optional multi-bit step checker: define JELLYVL_CDC_GRAY_STEP_CHECK_EN.
module jellyvl_cdc_gray_multi_sync
  import jellyvl_graycode_pkg::*;
#(
  parameter int    NUM_CH     = 1,
  parameter int    WIDTH      = 8,
  parameter int    SYNC_FF    = 3,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] s_gray,
  input  logic                    clear_err,
  output logic [NUM_CH*WIDTH-1:0] m_bin,
  output logic [NUM_CH*WIDTH-1:0] m_delta,
  output logic [NUM_CH-1:0]       m_valid,
  output logic [NUM_CH-1:0]       m_step_err,
  output logic                    m_ready
);

  localparam int CNT_W = $clog2(SYNC_FF + 1);

  // Width-specific wrapper around the package decoder.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [GRAY_MAX_W-1:0] wide;
    wide = gray_to_bin(GRAY_MAX_W'(g));
    return wide[WIDTH-1:0];
  endfunction

  logic [NUM_CH*WIDTH-1:0] sync_ff [SYNC_FF];
  logic [NUM_CH*WIDTH-1:0] sync_gray;
  logic [NUM_CH*WIDTH-1:0] sync_bin;
  logic [NUM_CH*WIDTH-1:0] prev_gray;
  logic [NUM_CH-1:0]       changed;
  state_t                  state;
  logic [CNT_W-1:0]        fill_cnt;

  // Configuration strings are informational only; no vendor primitives.
  logic [2:0] unused_cfg;
  assign unused_cfg = {DEVICE == "RTL", SIMULATION == "true", DEBUG == "true"};

  // Metastability chain: every channel shifts through SYNC_FF flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        sync_ff[i] <= '0;
      end
    end else begin
      sync_ff[0] <= s_gray;
      for (int i = 1; i < SYNC_FF; i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  // Decode the synchronised codes and detect per-channel changes.
  always_comb begin
    sync_gray = sync_ff[SYNC_FF-1];
    sync_bin  = '0;
    changed   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sync_bin[n*WIDTH +: WIDTH] = g2b(sync_gray[n*WIDTH +: WIDTH]);
      changed[n] = sync_gray[n*WIDTH +: WIDTH] != prev_gray[n*WIDTH +: WIDTH];
    end
  end

  // Shared FSM: wait for the chain to fill, load the baseline, then run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      fill_cnt <= '0;
      m_ready  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fill_cnt == CNT_W'(SYNC_FF - 1)) begin
            state <= PRIME;
          end
          fill_cnt <= fill_cnt + CNT_W'(1);
        end
        PRIME: begin
          state   <= RUN;
          m_ready <= 1'b1;
        end
        RUN: begin
          m_ready <= 1'b1;
        end
        default: begin
          state    <= FILL;
          fill_cnt <= '0;
          m_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel value, delta and change pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_bin     <= '0;
      m_delta   <= '0;
      m_valid   <= '0;
      prev_gray <= '0;
    end else begin
      case (state)
        PRIME: begin
          prev_gray <= sync_gray;
          m_bin     <= sync_bin;
          m_delta   <= '0;
          m_valid   <= '0;
        end
        RUN: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (changed[n]) begin
              m_bin[n*WIDTH +: WIDTH]     <= sync_bin[n*WIDTH +: WIDTH];
              m_delta[n*WIDTH +: WIDTH]   <= sync_bin[n*WIDTH +: WIDTH] - m_bin[n*WIDTH +: WIDTH];
              m_valid[n]                  <= 1'b1;
              prev_gray[n*WIDTH +: WIDTH] <= sync_gray[n*WIDTH +: WIDTH];
            end else begin
              m_valid[n] <= 1'b0;
            end
          end
        end
        default: begin
          m_valid <= '0;
        end
      endcase
    end
  end

`ifdef JELLYVL_CDC_GRAY_STEP_CHECK_EN
  // One sticky checker per channel, active only once running.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_step_check
    jellyvl_graycode_step_check #(
      .WIDTH(WIDTH)
    ) u_step_check (
      .clk     (clk),
      .reset   (reset),
      .prev    (prev_gray[n*WIDTH +: WIDTH]),
      .cur     (sync_gray[n*WIDTH +: WIDTH]),
      .check_en(state == RUN),
      .clear   (clear_err),
      .err     (m_step_err[n])
    );
  end
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign m_step_err       = '0;
`endif

endmodule
